// File: rtl/alu_issue_stage.sv
// ID-stage decode for the integer ALU subset, the ID/EX pipeline register with stall/flush,
// and the EX-stage forwarding muxes that present SrcA/SrcB/ALUControl to the ALU.
module alu_issue_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr_d,
   input  logic              valid_d,
   input  logic [XLEN-1:0]   rd1_d,
   input  logic [XLEN-1:0]   rd2_d,
   input  logic [XLEN-1:0]   imm_ext_d,
   input  logic              stall_e,
   input  logic              flush_e,
   input  logic [1:0]        forward_a_e,
   input  logic [1:0]        forward_b_e,
   input  logic [XLEN-1:0]   alu_result_m,
   input  logic [XLEN-1:0]   result_w,
   output logic [XLEN-1:0]   src_a_e,
   output logic [XLEN-1:0]   src_b_e,
   output logic [XLEN-1:0]   write_data_e,
   output logic [2:0]        alu_control_e,
   output logic [REG_AW-1:0] rd_e,
   output logic [REG_AW-1:0] rs1_e,
   output logic [REG_AW-1:0] rs2_e,
   output logic              reg_write_e,
   output logic              mem_write_e,
   output logic              result_src_e,
   output logic              branch_e,
   output logic              illegal_e,
   output logic              valid_e
);

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_op_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_write;
      logic              result_src;
      logic              branch;
      logic              illegal;
      logic              alu_src;
      logic [2:0]        alu_control;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
   } idex_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;
   logic       unused_instr_bits;

   assign opcode            = instr_d[6:0];
   assign funct3            = instr_d[14:12];
   assign funct7_b5         = instr_d[30];
   assign unused_instr_bits = ^{instr_d[31], instr_d[29:25]};

   alu_op_e dec_alu;
   logic    dec_alu_src;
   logic    dec_reg_write;
   logic    dec_mem_write;
   logic    dec_result_src;
   logic    dec_branch;
   logic    dec_illegal;

   always_comb begin
      dec_alu        = ALU_ADD;
      dec_alu_src    = 1'b0;
      dec_reg_write  = 1'b0;
      dec_mem_write  = 1'b0;
      dec_result_src = 1'b0;
      dec_branch     = 1'b0;
      dec_illegal    = 1'b0;
      case (opcode)
         OP_LOAD: begin
            if (funct3 == 3'b010) begin
               dec_alu_src    = 1'b1;
               dec_reg_write  = 1'b1;
               dec_result_src = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OP_STORE: begin
            if (funct3 == 3'b010) begin
               dec_alu_src   = 1'b1;
               dec_mem_write = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OP_BRANCH: begin
            if (funct3 == 3'b000) begin
               dec_alu    = ALU_SUB;
               dec_branch = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OP_REG, OP_IMM: begin
            // funct7 bit 5 only selects SUB for register-register forms; addi ignores it
            case (funct3)
               3'b000:  dec_alu = (opcode == OP_REG && funct7_b5) ? ALU_SUB : ALU_ADD;
               3'b010:  dec_alu = ALU_SLT;
               3'b110:  dec_alu = ALU_OR;
               3'b111:  dec_alu = ALU_AND;
               default: dec_illegal = 1'b1;
            endcase
            if (!dec_illegal) begin
               dec_reg_write = 1'b1;
               dec_alu_src   = (opcode == OP_IMM);
            end
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   idex_t capture;
   idex_t idex;

   // A non-valid slot still carries its operands, but none of its control may act.
   always_comb begin
      capture             = '0;
      capture.valid       = valid_d;
      capture.reg_write   = dec_reg_write  & valid_d;
      capture.mem_write   = dec_mem_write  & valid_d;
      capture.result_src  = dec_result_src & valid_d;
      capture.branch      = dec_branch     & valid_d;
      capture.illegal     = dec_illegal    & valid_d;
      capture.alu_src     = dec_alu_src    & valid_d;
      capture.alu_control = valid_d ? dec_alu : ALU_ADD;
      capture.rd1         = rd1_d;
      capture.rd2         = rd2_d;
      capture.imm         = imm_ext_d;
      capture.rs1         = instr_d[19:15];
      capture.rs2         = instr_d[24:20];
      capture.rd          = instr_d[11:7];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idex <= '0;
      end else if (flush_e) begin
         idex <= '0;
      end else if (!stall_e) begin
         idex <= capture;
      end
   end

   logic [XLEN-1:0] rd2_fwd;

   // Forward code 11 is reserved and falls back to the register value.
   always_comb begin
      case (forward_a_e)
         2'b10:   src_a_e = alu_result_m;
         2'b01:   src_a_e = result_w;
         default: src_a_e = idex.rd1;
      endcase
      case (forward_b_e)
         2'b10:   rd2_fwd = alu_result_m;
         2'b01:   rd2_fwd = result_w;
         default: rd2_fwd = idex.rd2;
      endcase
   end

   assign src_b_e       = idex.alu_src ? idex.imm : rd2_fwd;
   assign write_data_e  = rd2_fwd;
   assign alu_control_e = idex.alu_control;
   assign rd_e          = idex.rd;
   assign rs1_e         = idex.rs1;
   assign rs2_e         = idex.rs2;
   assign reg_write_e   = idex.reg_write;
   assign mem_write_e   = idex.mem_write;
   assign result_src_e  = idex.result_src;
   assign branch_e      = idex.branch;
   assign illegal_e     = idex.illegal;
   assign valid_e       = idex.valid;

endmodule
